// File: rtl/mem_responder.sv
// Memory-side target for the valid/ready request/response interface: one outstanding
// request, programmable or pseudo-random latency, byte-masked access to a word array.
module mem_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter int                FIXED_LAT = 1,
  parameter int                RAND_LAT  = 0,
  parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_wen,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int         BYTES = DATA_W / 8;
  localparam int         SHIFT = $clog2(BYTES);
  localparam int         IDX_W = $clog2(DEPTH);
  localparam int         LAT_W = $clog2(FIXED_LAT + 4) + 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'(BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic                ready_r;
  logic [LAT_W-1:0]    lat_cnt;
  logic [LAT_W-1:0]    lat_load;
  logic [7:0]          lfsr;
  logic                lfsr_fb;

  logic [ADDR_W-1:0]   addr_p0;
  logic                wen_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [BYTES-1:0]    wmask_p0;

  logic [ADDR_W-1:0]   off;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                accept;
  logic                access;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign req_ready = ready_r & ~rst;

  always_comb begin
    // An address below BASE_ADDR wraps to a huge offset and so fails the span check.
    off      = addr_p0 - BASE_ADDR;
    in_range = 64'(off) < SPAN;
    idx      = IDX_W'(off >> SHIFT);
    accept   = (state == IDLE) && req_valid && req_ready;
    access   = (state == WAIT) && (lat_cnt == LAT_W'(1)) && !rst;
    lat_load = LAT_W'(FIXED_LAT) + ((RAND_LAT != 0) ? LAT_W'(lfsr[1:0]) : '0);
    lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= req_addr;
      wen_p0   <= req_wen;
      wdata_p0 <= req_wdata;
      wmask_p0 <= req_wmask;
    end
  end

  // Array write at the access edge; never performed while rst is high
  always_ff @(posedge clk) begin
    if (access && wen_p0 && in_range) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wmask_p0[i]) mem[idx][i*8 +: 8] <= wdata_p0[i*8 +: 8];
      end
    end
  end

  // Control FSM and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_r   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_cnt   <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (state)
        IDLE: begin
          ready_r <= 1'b1;
          if (accept) begin
            ready_r <= 1'b0;
            lat_cnt <= lat_load;
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !in_range;
            rsp_rdata <= (in_range && !wen_p0) ? mem[idx] : '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            ready_r   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a fixed-latency instance and a random-latency instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic        f_rst, f_req_valid, f_req_ready, f_req_wen, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [31:0] f_req_addr, f_req_wdata, f_rsp_rdata;
  logic [3:0]  f_req_wmask;
  logic        r_rst, r_req_valid, r_req_ready, r_req_wen, r_rsp_valid, r_rsp_ready, r_rsp_err;
  logic [31:0] r_req_addr, r_req_wdata, r_rsp_rdata;
  logic [3:0]  r_req_wmask;

  mem_responder #(.FIXED_LAT(1), .RAND_LAT(0)) u_fix (
    .clk(clk), .rst(f_rst), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_addr(f_req_addr), .req_wen(f_req_wen), .req_wdata(f_req_wdata), .req_wmask(f_req_wmask),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err));

  mem_responder #(.FIXED_LAT(2), .RAND_LAT(1)) u_rnd (
    .clk(clk), .rst(r_rst), .req_valid(r_req_valid), .req_ready(r_req_ready),
    .req_addr(r_req_addr), .req_wen(r_req_wen), .req_wdata(r_req_wdata), .req_wmask(r_req_wmask),
    .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_rdata(r_rsp_rdata), .rsp_err(r_rsp_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the selected instance; caller must be idle with req_ready high.
  task automatic xact(input bit rnd, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, output logic [31:0] rdata, output logic err,
                      output int lat);
    if (rnd) begin
      r_req_valid = 1'b1; r_req_wen = wen; r_req_addr = addr; r_req_wdata = wdata; r_req_wmask = mask;
    end else begin
      f_req_valid = 1'b1; f_req_wen = wen; f_req_addr = addr; f_req_wdata = wdata; f_req_wmask = mask;
    end
    tick();
    f_req_valid = 1'b0;
    r_req_valid = 1'b0;
    lat = 0;
    while (!(rnd ? r_rsp_valid : f_rsp_valid) && lat < 20) begin
      tick();
      lat++;
    end
    rdata = rnd ? r_rsp_rdata : f_rsp_rdata;
    err   = rnd ? r_rsp_err : f_rsp_err;
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          hits [6];

  initial begin
    f_rst = 1'b1; f_req_valid = 1'b0; f_req_wen = 1'b0; f_req_addr = '0; f_req_wdata = '0;
    f_req_wmask = '0; f_rsp_ready = 1'b1;
    r_rst = 1'b1; r_req_valid = 1'b0; r_req_wen = 1'b0; r_req_addr = '0; r_req_wdata = '0;
    r_req_wmask = '0; r_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) hits[i] = 0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", f_rsp_valid, 0);
    chk("rst_rsp_err", f_rsp_err, 0);
    chk("rst_req_ready", f_req_ready, 0);
    f_rst = 1'b0;
    r_rst = 1'b0;
    tick();
    chk("post_rst_req_ready", f_req_ready, 1);

    // Write then read back
    xact(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("wr_lat", lat, 1);
    chk("wr_rdata", rd, 0);
    chk("wr_err", er, 0);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("rd_lat", lat, 1);
    chk("rd_rdata", rd, 32'hDEAD_BEEF);
    chk("idle_req_ready", f_req_ready, 1);

    // Byte mask
    xact(0, 1, 32'h8000_0010, 32'h1122_3344, 4'b0101, rd, er, lat);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("mask_rdata", rd, 32'hDE22_BE44);

    // Backpressure with a second request held during the response
    f_rsp_ready = 1'b0;
    f_req_valid = 1'b1; f_req_wen = 1'b0; f_req_addr = 32'h8000_0010;
    tick();
    f_req_wen = 1'b1; f_req_addr = 32'h8000_0014; f_req_wdata = 32'hCAFE_F00D; f_req_wmask = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", f_rsp_valid, 1);
      chk("bp_rsp_rdata", f_rsp_rdata, 32'hDE22_BE44);
      chk("bp_req_ready", f_req_ready, 0);
      tick();
    end
    f_rsp_ready = 1'b1;
    tick();
    chk("bp_after_hs_valid", f_rsp_valid, 0);
    chk("bp_after_hs_ready", f_req_ready, 1);
    tick();
    chk("bp_second_accepted", f_req_ready, 0);
    f_req_valid = 1'b0;
    tick();
    chk("bp_second_rsp_valid", f_rsp_valid, 1);
    chk("bp_second_rsp_rdata", f_rsp_rdata, 0);
    tick();
    xact(0, 0, 32'h8000_0014, 32'h0, 4'h0, rd, er, lat);
    chk("bp_second_readback", rd, 32'hCAFE_F00D);

    // Range boundaries
    xact(0, 0, 32'h8000_4000, 32'h0, 4'h0, rd, er, lat);
    chk("oob_hi_err", er, 1);
    chk("oob_hi_rdata", rd, 0);
    xact(0, 1, 32'h8000_3FFC, 32'h1234_5678, 4'hF, rd, er, lat);
    chk("last_wr_err", er, 0);
    xact(0, 0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er, lat);
    chk("last_rd_err", er, 0);
    chk("last_rd_rdata", rd, 32'h1234_5678);
    xact(0, 1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, rd, er, lat);
    xact(0, 1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("oob_lo_err", er, 1);
    chk("oob_lo_rdata", rd, 0);
    xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("word0_unchanged", rd, 32'h0BAD_F00D);

    // Zero mask write still responds, no change
    xact(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    chk("mask0_lat", lat, 1);
    xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("mask0_unchanged", rd, 32'h0BAD_F00D);

    // Reset on the access edge of a fixed-latency write
    f_req_valid = 1'b1; f_req_wen = 1'b1; f_req_addr = 32'h8000_0000;
    f_req_wdata = 32'h5555_5555; f_req_wmask = 4'hF;
    tick();
    f_req_valid = 1'b0;
    f_rst = 1'b1;
    tick();
    chk("fix_rst_rsp_valid", f_rsp_valid, 0);
    f_rst = 1'b0;
    tick();
    chk("fix_rst_rsp_valid2", f_rsp_valid, 0);
    xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("fix_rst_old_data", rd, 32'h0BAD_F00D);

    // Random latency distribution
    for (int i = 0; i < 200; i++) begin
      xact(1, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
      chk("rand_lat_range", (lat >= 2 && lat <= 5), 1);
      if (lat >= 2 && lat <= 5) hits[lat]++;
    end
    for (int l = 2; l <= 5; l++) chk($sformatf("rand_lat_hit_%0d", l), hits[l] > 0, 1);

    // Reset during WAIT of a random-latency write
    xact(1, 1, 32'h8000_0040, 32'h1111_1111, 4'hF, rd, er, lat);
    chk("rnd_wr_err", er, 0);
    r_req_valid = 1'b1; r_req_wen = 1'b1; r_req_addr = 32'h8000_0040;
    r_req_wdata = 32'h2222_2222; r_req_wmask = 4'hF;
    tick();
    r_req_valid = 1'b0;
    r_rst = 1'b1;
    tick();
    chk("rnd_rst_rsp_valid", r_rsp_valid, 0);
    chk("rnd_rst_req_ready", r_req_ready, 0);
    r_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rnd_rst_no_rsp", r_rsp_valid, 0);
    end
    xact(1, 0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
    chk("rnd_rst_old_data", rd, 32'h1111_1111);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
